// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage pipeline hazard control: result-select,
// forward-select and hazard sequencer state.
package riscv_pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } seq_state_e;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    else                                             return FWD_RF;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational E-stage operand forwarding selects for both ALU sources.
module forwarding_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs1_e_i,
  input  logic [4:0] rs2_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign fwd_b_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush and a
// data-memory wait sequencer with timeout. `HAZARD_PERF_EN adds perf counters.
module hazard_sequencer
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemErr
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             memerr_q, memerr_d;
  logic [1:0]       fwd_a, fwd_b;
  logic             lw_stall, mem_stall;

  forwarding_unit u_fwd (
    .rs1_e_i       (Rs1E),
    .rs2_e_i       (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
  );

  assign lw_stall  = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = (MemReqM && !MemReadyM) || (state_q == FAULT);
  assign MemErr    = memerr_q;

  // A memory freeze holds every stage; branch and load-use are re-evaluated once it lifts.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memerr_d = memerr_q;
    unique case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d = WAIT;
          wcnt_d  = CNT_W'(1);
        end
      end
      WAIT: begin
        // A request that vanishes mid-wait is treated as a completed access.
        if (MemReadyM || !MemReqM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == LAST_WAIT) begin
          state_d  = FAULT;
          memerr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      FAULT:   ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      wcnt_q   <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      memerr_q <= memerr_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (FlushD) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule
